// File: rtl/kbd_scan_decoder.sv
// PS/2 set-2 scan code decoder: pops codes from a keyboard FIFO, tracks prefixes, modifiers and
// typematic repeats, and emits one key event per make/break. The typematic flag is named key_repeat
// because repeat is a reserved word.
module kbd_scan_decoder #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [7:0]       data,
  input  logic             ready,
  output logic             nextdata_n,
  output logic             key_valid,
  output logic [7:0]       scan,
  output logic             extended,
  output logic             key_release,
  output logic             key_repeat,
  output logic [7:0]       ascii,
  output logic             shift,
  output logic             caps,
  output logic [CNT_W-1:0] press_count
);

  localparam logic [7:0] CODE_BREAK   = 8'hF0;
  localparam logic [7:0] CODE_EXT     = 8'hE0;
  localparam logic [7:0] CODE_SHIFT_L = 8'h12;
  localparam logic [7:0] CODE_SHIFT_R = 8'h59;
  localparam logic [7:0] CODE_CAPS    = 8'h58;

  typedef enum logic [1:0] {
    IDLE,
    POP,
    SETTLE
  } state_t;

  state_t      state;
  state_t      state_next;

  logic [7:0]  code;
  logic        brk;
  logic        ext;
  logic        shift_l;
  logic        shift_r;
  logic        caps_held;
  logic [8:0]  last_make;

  logic        is_make;
  logic [8:0]  key;
  logic        is_repeat;
  logic        is_mod;
  logic [7:0]  ascii_dec;

  // Letters map to an alphabet index; digits, space and enter are fixed. Extended keys never reach here.
  function automatic logic [7:0] ascii_of(input logic [7:0] c, input logic upper);
    logic [4:0] idx;
    logic       letter;
    logic [7:0] res;
    idx    = '0;
    letter = 1'b1;
    res    = '0;
    case (c)
      8'h1C: idx = 5'd0;   8'h32: idx = 5'd1;   8'h21: idx = 5'd2;   8'h23: idx = 5'd3;
      8'h24: idx = 5'd4;   8'h2B: idx = 5'd5;   8'h34: idx = 5'd6;   8'h33: idx = 5'd7;
      8'h43: idx = 5'd8;   8'h3B: idx = 5'd9;   8'h42: idx = 5'd10;  8'h4B: idx = 5'd11;
      8'h3A: idx = 5'd12;  8'h31: idx = 5'd13;  8'h44: idx = 5'd14;  8'h4D: idx = 5'd15;
      8'h15: idx = 5'd16;  8'h2D: idx = 5'd17;  8'h1B: idx = 5'd18;  8'h2C: idx = 5'd19;
      8'h3C: idx = 5'd20;  8'h2A: idx = 5'd21;  8'h1D: idx = 5'd22;  8'h22: idx = 5'd23;
      8'h35: idx = 5'd24;  8'h1A: idx = 5'd25;
      default: begin
        letter = 1'b0;
        case (c)
          8'h45: res = 8'h30;  8'h16: res = 8'h31;  8'h1E: res = 8'h32;  8'h26: res = 8'h33;
          8'h25: res = 8'h34;  8'h2E: res = 8'h35;  8'h36: res = 8'h36;  8'h3D: res = 8'h37;
          8'h3E: res = 8'h38;  8'h46: res = 8'h39;  8'h29: res = 8'h20;  8'h5A: res = 8'h0D;
          default: res = 8'h00;
        endcase
      end
    endcase
    if (letter) res = (upper ? 8'h41 : 8'h61) + {3'b000, idx};
    return res;
  endfunction

  always_ff @(posedge clk) begin
    if (clr) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (ready) state_next = POP;
      POP:     state_next = SETTLE;
      SETTLE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    is_make   = ~brk;
    key       = {ext, code};
    is_repeat = is_make && (key == last_make);
    is_mod    = ~ext && ((code == CODE_SHIFT_L) || (code == CODE_SHIFT_R) || (code == CODE_CAPS));
    ascii_dec = (is_make && ~ext) ? ascii_of(code, shift ^ caps) : 8'h00;
  end

  assign shift = shift_l | shift_r;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (clr) begin
      nextdata_n  <= 1'b1;
      key_valid   <= 1'b0;
      code        <= '0;
      scan        <= '0;
      extended    <= 1'b0;
      key_release <= 1'b0;
      key_repeat  <= 1'b0;
      ascii       <= '0;
      brk         <= 1'b0;
      ext         <= 1'b0;
      shift_l     <= 1'b0;
      shift_r     <= 1'b0;
      caps        <= 1'b0;
      caps_held   <= 1'b0;
      last_make   <= '0;
      press_count <= '0;
    end else begin
      key_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (ready) begin
            code       <= data;
            nextdata_n <= 1'b0;
          end else begin
            nextdata_n <= 1'b1;
          end
        end
        POP: begin
          nextdata_n <= 1'b1;
          if (code == CODE_BREAK) begin
            brk <= 1'b1;
          end else if (code == CODE_EXT) begin
            ext <= 1'b1;
          end else begin
            key_valid   <= 1'b1;
            scan        <= code;
            extended    <= ext;
            key_release <= brk;
            key_repeat  <= is_repeat;
            ascii       <= ascii_dec;
            brk         <= 1'b0;
            ext         <= 1'b0;
            if (is_make)                last_make <= key;
            else if (key == last_make)  last_make <= '0;
            if (~ext) begin
              case (code)
                CODE_SHIFT_L: shift_l <= is_make;
                CODE_SHIFT_R: shift_r <= is_make;
                CODE_CAPS: begin
                  // Caps toggles once per physical press; typematic repeats are ignored.
                  if (is_make) begin
                    if (~caps_held) caps <= ~caps;
                    caps_held <= 1'b1;
                  end else begin
                    caps_held <= 1'b0;
                  end
                end
                default: ;
              endcase
            end
            if (is_make && ~is_repeat && ~is_mod) press_count <= press_count + CNT_W'(1);
          end
        end
        default: nextdata_n <= 1'b1;
      endcase
    end
  end

endmodule
